addrgen_seq: RTL and testbench
==============================

Name: addrgen_seq

Overview:
- Job sequencer for the row/column address-generator unit that feeds the systolic tensor-core array.
- Accepts one matmul tile job (datatype + rc operand layout) via valid/ready and clears the address generator.
- Issues exactly the per-datatype number of enable beats, honouring downstream stalls, then waits a fixed drain window for the systolic skew to flush.
- Reports completion through a done valid/ready handshake.

Parameters:
- BEATS_FP, 64, enable beats per job for FP32 and FP16 (6-bit address sweep).
- BEATS_INT8, 16, enable beats per job for INT8.
- BEATS_INT4, 16, enable beats per job for INT4.
- DRAIN_CYC, 8, cycles between the last beat and done (systolic propagation skew); legal range 1..255.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  job request valid.
- req_ready  out  1  sequencer can accept a job.
- req_dtype  in  2  datatype; params encoding 0=FP32, 1=FP16, 2=INT8, 3=INT4.
- req_rc  in  2  operand layout; 00/01/10 legal, 11 illegal.
- stall  in  1  downstream back-pressure; suppresses beats.
- abort  in  1  cancel the current job.
- ag_clr  out  1  one-cycle clear pulse to the address generator.
- ag_en  out  1  address-generator enable (en_in).
- ag_cm  out  1  accumulate/compute-mode flag (cmin).
- ag_dtype  out  2  latched datatype to the generator.
- ag_rc  out  2  latched layout to the generator.
- busy  out  1  job in progress (state != IDLE).
- done_valid  out  1  job finished; held until accepted.
- done_ready  in  1  consumer accepts done.
- done_err  out  1  qualifies done_valid: job rejected (rc=11) or aborted.

Behaviour:
- State machine: IDLE, CLEAR, RUN, DRAIN, DONE. All outputs are registered.
- Reset values: state IDLE, req_ready 1, every other output 0. Async assert; deassert is used synchronously.
- IDLE:
  - req_ready=1.
  - On req_valid (handshake), latch dtype and rc into ag_dtype/ag_rc.
  - Load the beat target by dtype: 0,1→BEATS_FP; 2→BEATS_INT8; 3→BEATS_INT4.
  - If rc==11, go to DONE with done_err=1 and issue no ag_clr and no beats.
  - Otherwise go to CLEAR; req_ready drops the cycle after the handshake.
- CLEAR: ag_clr=1 for exactly one cycle, ag_en=0; then RUN.
- RUN:
  - ag_en=1 on each cycle with stall=0; each such cycle is one beat.
  - With stall=1, ag_en=0 and the beat counter holds.
  - ag_cm=0 on the first beat of a job and 1 on every later beat.
  - After the beat that makes the count equal the target, go to DRAIN. Exactly target beats, no more.
  - ag_dtype/ag_rc are stable from CLEAR until the job returns to IDLE.
- DRAIN: ag_en=0; a counter runs DRAIN_CYC cycles and is not affected by stall; then DONE.
- DONE:
  - done_valid=1, held with done_err stable until done_ready=1.
  - The accepting cycle returns to IDLE; req_ready=1 on the following cycle.
  - A new request is never accepted in the same cycle as done acceptance.
- abort:
  - Sampled in CLEAR, RUN or DRAIN: next state DONE with done_err=1, and ag_en=0 from the next cycle.
  - Ignored in IDLE and DONE.
  - abort together with stall: abort wins.
- Counters: beat counter 8 bits, drain counter 8 bits, both cleared on entry to CLEAR/DRAIN. No wrap occurs at legal parameters.
- Reset mid-job: every output returns to its reset value immediately. No done is reported for the killed job.

Optional Feature:
- Macro ADDRGEN_SEQ_PERF_EN.
- When defined, add outputs perf_busy_cyc[31:0] and perf_stall_cyc[31:0]:
  - perf_busy_cyc counts cycles spent in CLEAR/RUN/DRAIN.
  - perf_stall_cyc counts RUN cycles with stall=1.
  - Both saturate at all-ones, reset to 0, and clear when a new job is accepted.
- When undefined, these ports and counters do not exist and the core behaviour is identical.

Test Plan:
- FP32, rc=00, no stall:
  - ag_clr pulses once.
  - Exactly 64 consecutive ag_en cycles; ag_cm=0 on beat 1 only.
  - done_valid is asserted 8 cycles after the last beat; with done_ready=1, the job takes 1+64+8+1 cycles from accept.
- INT8, rc=10, stall high on beats 5-9 (5 cycles):
  - 16 ag_en beats spread over 21 cycles; no beats while stall=1.
  - ag_dtype=2 and ag_rc=2 held throughout.
- INT4 with rc=11: no ag_clr and no ag_en; done_valid with done_err=1 on the cycle after accept.
- FP16 job, abort on beat 30:
  - ag_en is low from the next cycle, then DONE with done_err=1.
  - A following INT4 job runs exactly 16 beats.
- done_ready held low 10 cycles:
  - done_valid and done_err stay stable and req_ready stays 0.
  - Acceptance returns to IDLE, and a second request queued on req_valid is taken one cycle later.
- rst_n asserted during RUN beat 20: all outputs 0 and req_ready 1 immediately; the next job starts cleanly with ag_clr.

Source files
------------

// File: rtl/addrgen_seq.sv
// Job sequencer for the systolic array's row/column address generator: accept, clear, beat, drain, done.
// Optional ADDRGEN_SEQ_PERF_EN adds saturating busy/stall cycle counters.
module addrgen_seq #(
  parameter int BEATS_FP   = 64,
  parameter int BEATS_INT8 = 16,
  parameter int BEATS_INT4 = 16,
  parameter int DRAIN_CYC  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_dtype,
  input  logic [1:0] req_rc,
  input  logic       stall,
  input  logic       abort,
  output logic       ag_clr,
  output logic       ag_en,
  output logic       ag_cm,
  output logic [1:0] ag_dtype,
  output logic [1:0] ag_rc,
  output logic       busy,
  output logic       done_valid,
  input  logic       done_ready,
  output logic       done_err
`ifdef ADDRGEN_SEQ_PERF_EN
  ,
  output logic [31:0] perf_busy_cyc,
  output logic [31:0] perf_stall_cyc
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [7:0] LP_BEATS_FP   = 8'(BEATS_FP);
  localparam logic [7:0] LP_BEATS_INT8 = 8'(BEATS_INT8);
  localparam logic [7:0] LP_BEATS_INT4 = 8'(BEATS_INT4);
  localparam logic [7:0] LP_DRAIN_LAST = 8'(DRAIN_CYC - 1);

  state_t     r_state, w_state_next;
  logic [7:0] r_beat_cnt, w_beat_cnt_next;
  logic [7:0] r_drain_cnt, w_drain_cnt_next;
  logic [7:0] r_target, w_target_next;
  logic       r_req_ready, w_req_ready_next;
  logic       r_ag_clr, w_ag_clr_next;
  logic       r_ag_en, w_ag_en_next;
  logic       r_ag_cm, w_ag_cm_next;
  logic [1:0] r_ag_dtype, w_ag_dtype_next;
  logic [1:0] r_ag_rc, w_ag_rc_next;
  logic       r_busy, w_busy_next;
  logic       r_done_valid, w_done_valid_next;
  logic       r_done_err, w_done_err_next;
  logic       w_accept;

  assign w_accept = (r_state == S_IDLE) && req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_beat_cnt   <= 8'd0;
      r_drain_cnt  <= 8'd0;
      r_target     <= 8'd0;
      r_req_ready  <= 1'b1;
      r_ag_clr     <= 1'b0;
      r_ag_en      <= 1'b0;
      r_ag_cm      <= 1'b0;
      r_ag_dtype   <= 2'd0;
      r_ag_rc      <= 2'd0;
      r_busy       <= 1'b0;
      r_done_valid <= 1'b0;
      r_done_err   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_beat_cnt   <= w_beat_cnt_next;
      r_drain_cnt  <= w_drain_cnt_next;
      r_target     <= w_target_next;
      r_req_ready  <= w_req_ready_next;
      r_ag_clr     <= w_ag_clr_next;
      r_ag_en      <= w_ag_en_next;
      r_ag_cm      <= w_ag_cm_next;
      r_ag_dtype   <= w_ag_dtype_next;
      r_ag_rc      <= w_ag_rc_next;
      r_busy       <= w_busy_next;
      r_done_valid <= w_done_valid_next;
      r_done_err   <= w_done_err_next;
    end
  end

  // Outputs are registered, so stall/abort sampled at an edge shape ag_en for the following cycle.
  // r_beat_cnt counts beats already presented, including the one on ag_en right now.
  always_comb begin
    w_state_next      = r_state;
    w_beat_cnt_next   = r_beat_cnt;
    w_drain_cnt_next  = r_drain_cnt;
    w_target_next     = r_target;
    w_req_ready_next  = r_req_ready;
    w_ag_clr_next     = 1'b0;
    w_ag_en_next      = 1'b0;
    w_ag_cm_next      = 1'b0;
    w_ag_dtype_next   = r_ag_dtype;
    w_ag_rc_next      = r_ag_rc;
    w_done_valid_next = r_done_valid;
    w_done_err_next   = r_done_err;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_ag_dtype_next  = req_dtype;
          w_ag_rc_next     = req_rc;
          w_req_ready_next = 1'b0;
          case (req_dtype)
            2'd0, 2'd1: w_target_next = LP_BEATS_FP;
            2'd2:       w_target_next = LP_BEATS_INT8;
            default:    w_target_next = LP_BEATS_INT4;
          endcase
          if (req_rc == 2'b11) begin
            w_state_next      = S_DONE;
            w_done_valid_next = 1'b1;
            w_done_err_next   = 1'b1;
          end else begin
            w_state_next    = S_CLEAR;
            w_ag_clr_next   = 1'b1;
            w_beat_cnt_next = 8'd0;
          end
        end
      end
      S_CLEAR: begin
        if (abort) begin
          w_state_next      = S_DONE;
          w_done_valid_next = 1'b1;
          w_done_err_next   = 1'b1;
        end else begin
          w_state_next = S_RUN;
          if (!stall) begin
            w_ag_en_next    = 1'b1;
            w_beat_cnt_next = 8'd1;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_next      = S_DONE;
          w_done_valid_next = 1'b1;
          w_done_err_next   = 1'b1;
        end else if (r_beat_cnt == r_target) begin
          w_state_next     = S_DRAIN;
          w_drain_cnt_next = 8'd0;
        end else if (!stall) begin
          w_ag_en_next    = 1'b1;
          w_ag_cm_next    = (r_beat_cnt != 8'd0);
          w_beat_cnt_next = r_beat_cnt + 8'd1;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          w_state_next      = S_DONE;
          w_done_valid_next = 1'b1;
          w_done_err_next   = 1'b1;
        end else if (r_drain_cnt == LP_DRAIN_LAST) begin
          w_state_next      = S_DONE;
          w_done_valid_next = 1'b1;
          w_done_err_next   = 1'b0;
        end else begin
          w_drain_cnt_next = r_drain_cnt + 8'd1;
        end
      end
      S_DONE: begin
        if (done_ready) begin
          w_state_next      = S_IDLE;
          w_req_ready_next  = 1'b1;
          w_done_valid_next = 1'b0;
          w_done_err_next   = 1'b0;
        end
      end
      default: begin
        w_state_next     = S_IDLE;
        w_req_ready_next = 1'b1;
      end
    endcase

    w_busy_next = (w_state_next != S_IDLE);
  end

  assign req_ready  = r_req_ready;
  assign ag_clr     = r_ag_clr;
  assign ag_en      = r_ag_en;
  assign ag_cm      = r_ag_cm;
  assign ag_dtype   = r_ag_dtype;
  assign ag_rc      = r_ag_rc;
  assign busy       = r_busy;
  assign done_valid = r_done_valid;
  assign done_err   = r_done_err;

`ifdef ADDRGEN_SEQ_PERF_EN
  logic [31:0] r_perf_busy;
  logic [31:0] r_perf_stall;
  logic        w_active;

  assign w_active = (r_state == S_CLEAR) || (r_state == S_RUN) || (r_state == S_DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_busy  <= 32'd0;
      r_perf_stall <= 32'd0;
    end else if (w_accept) begin
      r_perf_busy  <= 32'd0;
      r_perf_stall <= 32'd0;
    end else begin
      if (w_active && (r_perf_busy != 32'hFFFF_FFFF)) begin
        r_perf_busy <= r_perf_busy + 32'd1;
      end
      if ((r_state == S_RUN) && stall && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_busy_cyc  = r_perf_busy;
  assign perf_stall_cyc = r_perf_stall;
`endif

endmodule

// File: tb/tb_addrgen_seq.sv
// Bench for addrgen_seq: directed table of jobs plus randomized jobs, each checked cycle by cycle
// against a job-level model (beat slots, drain length, abort cut-off) computed with plain arithmetic.
module tb_addrgen_seq;
  localparam int BEATS_FP   = 64;
  localparam int BEATS_INT8 = 16;
  localparam int BEATS_INT4 = 16;
  localparam int DRAIN_CYC  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_dtype = 2'd0;
  logic [1:0] req_rc = 2'd0;
  logic       stall = 1'b0;
  logic       abort = 1'b0;
  logic       ag_clr, ag_en, ag_cm;
  logic [1:0] ag_dtype, ag_rc;
  logic       busy, done_valid, done_err;
  logic       done_ready = 1'b0;

  addrgen_seq #(
    .BEATS_FP(BEATS_FP), .BEATS_INT8(BEATS_INT8), .BEATS_INT4(BEATS_INT4), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_dtype(req_dtype), .req_rc(req_rc),
    .stall(stall), .abort(abort),
    .ag_clr(ag_clr), .ag_en(ag_en), .ag_cm(ag_cm), .ag_dtype(ag_dtype), .ag_rc(ag_rc),
    .busy(busy), .done_valid(done_valid), .done_ready(done_ready), .done_err(done_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] dtype;
    logic [1:0] rc;
    int         stall_start;
    int         stall_len;
    int         abort_at;
    int         hold;
    bit         nx;
    int         rst_at;
    int         exp_beats;
    int         exp_done;
    bit         exp_err;
  } vec_t;

  vec_t tbl[0:10];
  int   n_pass = 0;
  int   n_total = 0;
  int   job_id = 0;

  // Cycle k counts from the accept edge (k=1 is the first cycle after it).
  // stall_mask[k] is the stall level driven during cycle k.
  bit stall_mask[0:511];
  bit m_en[0:511];
  int m_done;
  bit m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic int target_of(input logic [1:0] dt);
    case (dt)
      2'd0, 2'd1: return BEATS_FP;
      2'd2:       return BEATS_INT8;
      default:    return BEATS_INT4;
    endcase
  endfunction

  // Job-level model: beat slots start at cycle 2; a slot carries a beat when stall was low in
  // the previous cycle and beats remain; done follows the last beat after DRAIN_CYC cycles.
  task automatic model_job(input int tgt, input logic [1:0] rc, input int abort_at);
    int cnt, k;
    for (int i = 0; i < 512; i++) m_en[i] = 1'b0;
    if (rc == 2'b11) begin
      m_done = 1;
      m_err  = 1'b1;
      return;
    end
    cnt = 0;
    k   = 2;
    while (cnt < tgt && k < 480) begin
      if (!stall_mask[k-1]) begin
        m_en[k] = 1'b1;
        cnt++;
      end
      k++;
    end
    m_done = (k - 1) + DRAIN_CYC + 1;
    m_err  = 1'b0;
    if (abort_at != 0 && abort_at < m_done) begin
      for (int i = abort_at + 1; i < 512; i++) m_en[i] = 1'b0;
      m_done = abort_at + 1;
      m_err  = 1'b1;
    end
  endtask

  task automatic run_job(input logic [1:0] dt, input logic [1:0] rc, input int abort_at,
                         input int hold, input bit nx_v, input logic [1:0] nx_dt,
                         input logic [1:0] nx_rc, input int rst_at, input int exp_beats,
                         input int exp_done, input bit exp_err);
    int          k_end, bnum, obs_beats, obs_done;
    logic        obs_err;
    logic [6:0]  ia;
    logic [10:0] act, exp;
    model_job(target_of(dt), rc, abort_at);
    k_end = m_done + hold;
    job_id++;
    @(negedge clk);
    done_ready = 1'b0;
    ia = {ag_clr, ag_en, ag_en & ag_cm, done_valid, done_valid & done_err, busy, req_ready};
    chk($sformatf("job%0d idle before accept", job_id), 32'(ia), 32'h01);
    req_valid = 1'b1;
    req_dtype = dt;
    req_rc    = rc;
    stall     = stall_mask[0];
    abort     = 1'b0;
    bnum      = 0;
    obs_beats = 0;
    obs_done  = -1;
    obs_err   = 1'b0;
    for (int k = 1; k <= k_end; k++) begin
      @(negedge clk);
      if (m_en[k]) bnum++;
      exp = {(k == 1 && rc != 2'b11), m_en[k], m_en[k] && bnum > 1, k >= m_done,
             (k >= m_done) && m_err, 1'b1, 1'b0, dt, rc};
      act = {ag_clr, ag_en, ag_en & ag_cm, done_valid, done_valid & done_err, busy, req_ready,
             ag_dtype, ag_rc};
      chk($sformatf("job%0d cycle%0d outputs", job_id, k), 32'(act), 32'(exp));
      if (ag_en) obs_beats++;
      if (done_valid && obs_done < 0) begin
        obs_done = k;
        obs_err  = done_err;
      end
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        act = {ag_clr, ag_en, ag_cm, done_valid, done_err, busy, req_ready, ag_dtype, ag_rc};
        chk($sformatf("job%0d async reset outputs", job_id), 32'(act), 32'h010);
        stall     = 1'b0;
        abort     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
      if (nx_v && k >= m_done) begin
        req_valid = 1'b1;
        req_dtype = nx_dt;
        req_rc    = nx_rc;
      end else begin
        req_valid = 1'b0;
      end
      stall      = stall_mask[k];
      abort      = (k == abort_at);
      done_ready = (k >= k_end);
    end
    stall = 1'b0;
    abort = 1'b0;
    if (exp_beats >= 0) chk($sformatf("job%0d beat count", job_id), 32'(obs_beats), 32'(exp_beats));
    if (exp_done >= 0) begin
      chk($sformatf("job%0d done cycle", job_id), 32'(obs_done), 32'(exp_done));
      chk($sformatf("job%0d done_err", job_id), 32'(obs_err), 32'(exp_err));
    end
  endtask

  initial begin
    int p;
    // dtype, rc, stall_start, stall_len, abort_at, hold, nx, rst_at, exp_beats, exp_done, exp_err
    tbl[0]  = '{2'd0, 2'd0, 0, 0, 0,  0,  1'b0, 0,  64, 74, 1'b0};  // FP32 plain
    tbl[1]  = '{2'd2, 2'd2, 5, 5, 0,  0,  1'b0, 0,  16, 31, 1'b0};  // INT8, 5 stall cycles
    tbl[2]  = '{2'd3, 2'd3, 0, 0, 0,  0,  1'b0, 0,  0,  1,  1'b1};  // illegal layout
    tbl[3]  = '{2'd1, 2'd0, 0, 0, 31, 0,  1'b0, 0,  30, 32, 1'b1};  // FP16 abort on beat 30
    tbl[4]  = '{2'd3, 2'd1, 0, 0, 0,  0,  1'b0, 0,  16, 26, 1'b0};  // INT4 after abort
    tbl[5]  = '{2'd2, 2'd0, 0, 0, 0,  10, 1'b1, 0,  16, 26, 1'b0};  // slow done, next queued
    tbl[6]  = '{2'd0, 2'd1, 0, 0, 0,  0,  1'b0, 21, 20, -1, 1'b0};  // reset on beat 20
    tbl[7]  = '{2'd2, 2'd0, 0, 0, 0,  0,  1'b0, 0,  16, 26, 1'b0};  // clean after reset
    tbl[8]  = '{2'd2, 2'd2, 0, 0, 1,  0,  1'b0, 0,  0,  2,  1'b1};  // abort in clear
    tbl[9]  = '{2'd3, 2'd0, 0, 0, 20, 0,  1'b0, 0,  16, 21, 1'b1};  // abort in drain
    tbl[10] = '{2'd2, 2'd0, 5, 4, 6,  0,  1'b0, 0,  4,  7,  1'b1};  // abort with stall

    repeat (2) @(negedge clk);
    chk("reset state", 32'({ag_clr, ag_en, ag_cm, done_valid, done_err, busy, req_ready,
                            ag_dtype, ag_rc}), 32'h010);
    rst_n = 1'b1;

    for (int i = 0; i <= 10; i++) begin
      for (int k = 0; k < 512; k++)
        stall_mask[k] = (k >= tbl[i].stall_start) && (k < tbl[i].stall_start + tbl[i].stall_len)
                        && (tbl[i].stall_len > 0);
      run_job(tbl[i].dtype, tbl[i].rc, tbl[i].abort_at, tbl[i].hold, tbl[i].nx,
              (i < 10) ? tbl[(i < 10) ? i + 1 : i].dtype : 2'd0,
              (i < 10) ? tbl[(i < 10) ? i + 1 : i].rc : 2'd0,
              tbl[i].rst_at, tbl[i].exp_beats, tbl[i].exp_done, tbl[i].exp_err);
    end

    for (int j = 0; j < 40; j++) begin
      logic [1:0] dt, rc;
      int         ab, hd;
      dt = 2'($urandom_range(0, 3));
      rc = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      p  = $urandom_range(0, 40);
      for (int k = 0; k < 512; k++)
        stall_mask[k] = (k > 0) && (k < 300) && ($urandom_range(0, 99) < p);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 90) : 0;
      hd = $urandom_range(0, 3);
      run_job(dt, rc, ab, hd, 1'b0, 2'd0, 2'd0, 0, -1, -1, 1'b0);
    end

    @(negedge clk);
    chk("final idle", 32'({ag_en, done_valid, busy, req_ready}), 32'h1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
